// File: rtl/decode_fwd_stage.sv
// ----------------------------------------------------------------------------
// decode_fwd_stage
//
// Purpose:
//   Decode-side operand resolution and branch evaluation stage. Each source
//   operand is taken from the youngest matching forwarding channel, or from
//   the register file when nothing matches. A matching channel whose data is
//   still in flight stalls the stage. The resolved operands, the branch
//   decision and the branch target are captured in a single output register
//   with a valid/ready handshake on both sides.
//
// Ports:
//   clk, resetn           clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   upstream handshake for the decoded instruction
//   in_srca, in_srcb      source register ids (id 0 reads as zero register)
//   in_usea, in_useb      source operand is actually read
//   in_dst, in_pc, in_imm destination id, PC, immediate / branch offset
//   in_brk                branch kind: 0 none, 1 EQ, 2 NE, 3 LTZ, 4 GEZ,
//                         5 LEZ, 6 GTZ, 7 none
//   rval_a, rval_b        register-file read data
//   fwd_valid             per channel: channel carries a write
//   fwd_pending           per channel: write data not yet available
//   fwd_dst, fwd_data     per channel destination id / data, packed
//   flush                 kill the stage contents
//   out_valid / out_ready downstream handshake
//   out_vala, out_valb    resolved operands
//   out_imm, out_dst,
//   out_pc                registered instruction fields
//   br_taken, br_target   registered branch decision and target
//   stall_cnt             saturating count of hazard-stalled cycles
// ----------------------------------------------------------------------------
module decode_fwd_stage #(
   parameter int DATA_W  = 32,
   parameter int REG_W   = 5,
   parameter int NUM_FWD = 4,
   parameter int CNT_W   = 16
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [REG_W-1:0]           in_srca,
   input  logic [REG_W-1:0]           in_srcb,
   input  logic                       in_usea,
   input  logic                       in_useb,
   input  logic [REG_W-1:0]           in_dst,
   input  logic [DATA_W-1:0]          in_pc,
   input  logic [DATA_W-1:0]          in_imm,
   input  logic [2:0]                 in_brk,
   input  logic [DATA_W-1:0]          rval_a,
   input  logic [DATA_W-1:0]          rval_b,
   input  logic [NUM_FWD-1:0]         fwd_valid,
   input  logic [NUM_FWD-1:0]         fwd_pending,
   input  logic [NUM_FWD*REG_W-1:0]   fwd_dst,
   input  logic [NUM_FWD*DATA_W-1:0]  fwd_data,
   input  logic                       flush,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_W-1:0]          out_vala,
   output logic [DATA_W-1:0]          out_valb,
   output logic [DATA_W-1:0]          out_imm,
   output logic [REG_W-1:0]           out_dst,
   output logic [DATA_W-1:0]          out_pc,
   output logic                       br_taken,
   output logic [DATA_W-1:0]          br_target,
   output logic [CNT_W-1:0]           stall_cnt
);

   localparam logic [DATA_W-1:0] PC_STEP = DATA_W'(4);
   localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

   // Unpacked views of the packed forwarding buses
   logic [REG_W-1:0]  w_ch_dst  [NUM_FWD];
   logic [DATA_W-1:0] w_ch_data [NUM_FWD];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_FWD; gi++) begin : g_ch
         assign w_ch_dst[gi]  = fwd_dst[gi*REG_W +: REG_W];
         assign w_ch_data[gi] = fwd_data[gi*DATA_W +: DATA_W];
      end
   endgenerate

   logic [DATA_W-1:0] w_opa, w_opb;
   logic              w_pend_a, w_pend_b;
   logic              w_hazard;
   logic              w_in_ready;
   logic              w_load;
   logic              w_br_taken;
   logic [DATA_W-1:0] w_br_target;

   logic              r_out_valid;
   logic [DATA_W-1:0] r_vala, r_valb, r_imm, r_pc, r_br_target;
   logic [REG_W-1:0]  r_dst;
   logic              r_br_taken;
   logic [CNT_W-1:0]  r_stall_cnt;

   // Source A: scan from the oldest channel towards channel 0 so the
   // youngest match is the last one written. The pending flag travels with
   // the selected channel, so an older pending write never stalls a source
   // that a younger ready write already supplies.
   always_comb begin
      w_opa    = rval_a;
      w_pend_a = 1'b0;
      if (in_usea && (in_srca != '0)) begin
         for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_valid[i] && (w_ch_dst[i] == in_srca)) begin
               w_opa    = w_ch_data[i];
               w_pend_a = fwd_pending[i];
            end
         end
      end
   end

   // Source B: same selection as source A
   always_comb begin
      w_opb    = rval_b;
      w_pend_b = 1'b0;
      if (in_useb && (in_srcb != '0)) begin
         for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_valid[i] && (w_ch_dst[i] == in_srcb)) begin
               w_opb    = w_ch_data[i];
               w_pend_b = fwd_pending[i];
            end
         end
      end
   end

   assign w_hazard   = w_pend_a | w_pend_b;
   assign w_in_ready = !flush && !w_hazard && (!r_out_valid || out_ready);
   assign w_load     = in_valid && w_in_ready;

   // Branch evaluation on the resolved operands; zero compares are signed,
   // so the sign bit alone decides negative.
   always_comb begin
      w_br_taken = 1'b0;
      case (in_brk)
         3'd1:    w_br_taken = (w_opa == w_opb);
         3'd2:    w_br_taken = (w_opa != w_opb);
         3'd3:    w_br_taken = w_opa[DATA_W-1];
         3'd4:    w_br_taken = !w_opa[DATA_W-1];
         3'd5:    w_br_taken = w_opa[DATA_W-1] || (w_opa == '0);
         3'd6:    w_br_taken = !w_opa[DATA_W-1] && (w_opa != '0);
         default: w_br_taken = 1'b0;
      endcase
   end

   assign w_br_target = in_pc + PC_STEP + in_imm;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_out_valid <= 1'b0;
         r_vala      <= '0;
         r_valb      <= '0;
         r_imm       <= '0;
         r_dst       <= '0;
         r_pc        <= '0;
         r_br_taken  <= 1'b0;
         r_br_target <= '0;
         r_stall_cnt <= '0;
      end else begin
         // flush wins over everything; a load implies flush is low
         if (flush) begin
            r_out_valid <= 1'b0;
         end else if (w_load) begin
            r_out_valid <= 1'b1;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end

         // Data registers change only on a load, so they hold under backpressure
         if (w_load) begin
            r_vala      <= w_opa;
            r_valb      <= w_opb;
            r_imm       <= in_imm;
            r_dst       <= in_dst;
            r_pc        <= in_pc;
            r_br_taken  <= w_br_taken;
            r_br_target <= w_br_target;
         end

         // Hazard cycles count even when the output register is also full
         if (in_valid && w_hazard && !flush && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_ONE;
         end
      end
   end

   assign in_ready  = w_in_ready;
   assign out_valid = r_out_valid;
   assign out_vala  = r_vala;
   assign out_valb  = r_valb;
   assign out_imm   = r_imm;
   assign out_dst   = r_dst;
   assign out_pc    = r_pc;
   assign br_taken  = r_br_taken;
   assign br_target = r_br_target;
   assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_decode_fwd_stage.sv
// ----------------------------------------------------------------------------
// tb_decode_fwd_stage
//
// Directed bench for decode_fwd_stage. Each accepted instruction pushes its
// hand-computed expected result into a scoreboard queue; an independent
// monitor pops and compares whenever the stage hands an output downstream.
// Stall, hold, flush, saturation and reset behaviour are checked inline.
// The counter width is reduced so saturation is reached in a few hundred
// cycles.
// ----------------------------------------------------------------------------
module tb_decode_fwd_stage;

   localparam int DW = 32;
   localparam int RW = 5;
   localparam int NF = 4;
   localparam int CW = 8;
   localparam logic [31:0] SAT = 32'h0000_00FF;

   logic              clk = 1'b0;
   logic              resetn;
   logic              in_valid, in_ready;
   logic [RW-1:0]     in_srca, in_srcb, in_dst;
   logic              in_usea, in_useb;
   logic [DW-1:0]     in_pc, in_imm, rval_a, rval_b;
   logic [2:0]        in_brk;
   logic [NF-1:0]     fwd_valid, fwd_pending;
   logic [NF*RW-1:0]  fwd_dst;
   logic [NF*DW-1:0]  fwd_data;
   logic              flush;
   logic              out_valid, out_ready;
   logic [DW-1:0]     out_vala, out_valb, out_imm, out_pc, br_target;
   logic [RW-1:0]     out_dst;
   logic              br_taken;
   logic [CW-1:0]     stall_cnt;

   decode_fwd_stage #(
      .DATA_W (DW), .REG_W (RW), .NUM_FWD (NF), .CNT_W (CW)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_srca     (in_srca),
      .in_srcb     (in_srcb),
      .in_usea     (in_usea),
      .in_useb     (in_useb),
      .in_dst      (in_dst),
      .in_pc       (in_pc),
      .in_imm      (in_imm),
      .in_brk      (in_brk),
      .rval_a      (rval_a),
      .rval_b      (rval_b),
      .fwd_valid   (fwd_valid),
      .fwd_pending (fwd_pending),
      .fwd_dst     (fwd_dst),
      .fwd_data    (fwd_data),
      .flush       (flush),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_vala    (out_vala),
      .out_valb    (out_valb),
      .out_imm     (out_imm),
      .out_dst     (out_dst),
      .out_pc      (out_pc),
      .br_taken    (br_taken),
      .br_target   (br_target),
      .stall_cnt   (stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] vala;
      logic [31:0] valb;
      logic [31:0] imm;
      logic [4:0]  dst;
      logic [31:0] pc;
      logic        taken;
      logic [31:0] target;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // Branch vector table: kind, operand A, operand B, pc, imm, target, taken
   localparam int NBR = 13;
   localparam logic [2:0]  BR_K [NBR] = '{3'd6, 3'd2, 3'd2, 3'd1, 3'd3, 3'd3, 3'd4,
                                          3'd4, 3'd5, 3'd5, 3'd6, 3'd7, 3'd0};
   localparam logic [31:0] BR_A [NBR] = '{32'h8000_0000, 32'h11, 32'h1, 32'h1,
                                          32'hFFFF_FFFF, 32'h0, 32'h0, 32'h8000_0000,
                                          32'h0, 32'h1, 32'h1, 32'h0, 32'h5};
   localparam logic [31:0] BR_B [NBR] = '{32'h0, 32'h11, 32'h2, 32'h2, 32'h0, 32'h0,
                                          32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h5};
   localparam logic [31:0] BR_PC [NBR] = '{32'h500, 32'h504, 32'h508, 32'h50C, 32'h510,
                                           32'h514, 32'h518, 32'h51C, 32'h520, 32'h524,
                                           32'h528, 32'h52C, 32'hFFFF_FFF0};
   localparam logic [31:0] BR_IMM [NBR] = '{32'h0, 32'h8, 32'hFFFF_FFF8, 32'h100, 32'h0,
                                            32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                            32'h0, 32'h10};
   localparam logic [31:0] BR_TGT [NBR] = '{32'h504, 32'h510, 32'h504, 32'h610, 32'h514,
                                            32'h518, 32'h51C, 32'h520, 32'h524, 32'h528,
                                            32'h52C, 32'h530, 32'h4};
   localparam logic        BR_TK [NBR] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
                                           1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      in_valid    = 1'b0;
      in_srca     = '0;
      in_srcb     = '0;
      in_usea     = 1'b0;
      in_useb     = 1'b0;
      in_dst      = '0;
      in_pc       = '0;
      in_imm      = '0;
      in_brk      = '0;
      rval_a      = '0;
      rval_b      = '0;
      fwd_valid   = '0;
      fwd_pending = '0;
      fwd_dst     = '0;
      fwd_data    = '0;
      flush       = 1'b0;
   endtask

   task automatic set_ch(input int ch, input logic v, input logic p,
                         input logic [RW-1:0] d, input logic [DW-1:0] data);
      fwd_valid[ch]          = v;
      fwd_pending[ch]        = p;
      fwd_dst[ch*RW +: RW]   = d;
      fwd_data[ch*DW +: DW]  = data;
   endtask

   // Present the current inputs until accepted (bounded), queuing the
   // expected result at the acceptance edge.
   task automatic issue(input exp_t e, input int budget, input string name);
      bit done;
      done     = 1'b0;
      in_valid = 1'b1;
      for (int c = 0; c < budget && !done; c++) begin
         @(negedge clk);
         if (in_ready) begin
            sb.push_back(e);
            done = 1'b1;
         end
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL %s_accept: in_ready stayed 0 for %0d cycles, expected acceptance", name, budget);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain(input int budget);
      for (int c = 0; c < budget && sb.size() != 0; c++) @(posedge clk);
      #1;
      chk("drain", 32'(sb.size()), 32'd0);
   endtask

   // Monitor: compare every output handed downstream against the queue head
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (resetn && out_valid && out_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected: output pc=0x%08h with no expected entry", out_pc);
            end else begin
               e = sb.pop_front();
               $display("txn pc=0x%08h vala=0x%08h valb=0x%08h dst=%0d taken=%0b target=0x%08h",
                        out_pc, out_vala, out_valb, out_dst, br_taken, br_target);
               chk("out_vala",  out_vala,        e.vala);
               chk("out_valb",  out_valb,        e.valb);
               chk("out_imm",   out_imm,         e.imm);
               chk("out_dst",   32'(out_dst),    32'(e.dst));
               chk("out_pc",    out_pc,          e.pc);
               chk("br_taken",  32'(br_taken),   32'(e.taken));
               chk("br_target", br_target,       e.target);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      resetn    = 1'b0;
      out_ready = 1'b1;
      clear_inputs();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_br_taken",  32'(br_taken),  32'd0);
      chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      chk("rst_out_vala",  out_vala,       32'd0);
      chk("rst_out_pc",    out_pc,         32'd0);
      chk("rst_br_target", br_target,      32'd0);
      resetn = 1'b1;
      @(posedge clk);
      #1;

      // Youngest matching channel wins; id 0 source reads the register file
      clear_inputs();
      rval_a = 32'h5;  in_srca = 5'd3; in_usea = 1'b1;
      rval_b = 32'h22; in_srcb = 5'd0; in_useb = 1'b1;
      set_ch(2, 1'b1, 1'b0, 5'd3, 32'h9);
      set_ch(0, 1'b1, 1'b0, 5'd3, 32'h7);
      in_dst = 5'd9; in_pc = 32'h40; in_imm = 32'h8;
      issue('{vala: 32'h7, valb: 32'h22, imm: 32'h8, dst: 5'd9, pc: 32'h40,
              taken: 1'b0, target: 32'h4C}, 1, "fwd_priority");

      // Zero register ignores a channel writing id 0; unused source ignores
      // a pending match
      clear_inputs();
      rval_a = 32'h1234; in_srca = 5'd0; in_usea = 1'b1;
      rval_b = 32'hBB;   in_srcb = 5'd3; in_useb = 1'b0;
      set_ch(0, 1'b1, 1'b0, 5'd0, 32'hFFFF);
      set_ch(1, 1'b1, 1'b1, 5'd3, 32'hCC);
      in_pc = 32'h80;
      issue('{vala: 32'h1234, valb: 32'hBB, imm: 32'h0, dst: 5'd0, pc: 32'h80,
              taken: 1'b0, target: 32'h84}, 1, "zero_reg");

      // Invalid channel skipped; older pending match shadowed by younger ready one
      clear_inputs();
      rval_a = 32'h1; in_srca = 5'd4; in_usea = 1'b1;
      rval_b = 32'h2; in_srcb = 5'd6; in_useb = 1'b1;
      set_ch(0, 1'b0, 1'b0, 5'd4, 32'h99);
      set_ch(1, 1'b1, 1'b0, 5'd4, 32'h44);
      set_ch(2, 1'b1, 1'b0, 5'd6, 32'h66);
      set_ch(3, 1'b1, 1'b1, 5'd6, 32'h55);
      in_dst = 5'd7; in_pc = 32'h200; in_imm = 32'h10;
      issue('{vala: 32'h44, valb: 32'h66, imm: 32'h10, dst: 5'd7, pc: 32'h200,
              taken: 1'b0, target: 32'h214}, 1, "fwd_skip");

      // Pending youngest match stalls for three cycles even though an older
      // channel holds ready data
      clear_inputs();
      rval_b = 32'h5; in_srca = 5'd3; in_usea = 1'b1;
      set_ch(0, 1'b1, 1'b1, 5'd3, 32'hDEAD);
      set_ch(1, 1'b1, 1'b0, 5'd3, 32'h31);
      in_dst = 5'd2; in_pc = 32'h300; in_imm = 32'h4; in_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("stall_in_ready", 32'(in_ready), 32'd0);
      end
      @(posedge clk);
      #1;
      chk("stall_cnt_3", 32'(stall_cnt), 32'd3);
      set_ch(0, 1'b1, 1'b0, 5'd3, 32'h77);
      issue('{vala: 32'h77, valb: 32'h5, imm: 32'h4, dst: 5'd2, pc: 32'h300,
              taken: 1'b0, target: 32'h308}, 1, "stall_release");
      chk("stall_cnt_after", 32'(stall_cnt), 32'd3);

      // Hazard on source B
      clear_inputs();
      rval_a = 32'h10; in_srcb = 5'd5; in_useb = 1'b1;
      set_ch(2, 1'b1, 1'b1, 5'd5, 32'h0);
      in_dst = 5'd4; in_pc = 32'h400; in_valid = 1'b1;
      @(negedge clk);
      chk("hazb_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      chk("hazb_stall_cnt", 32'(stall_cnt), 32'd4);
      set_ch(2, 1'b1, 1'b0, 5'd5, 32'h5A);
      issue('{vala: 32'h10, valb: 32'h5A, imm: 32'h0, dst: 5'd4, pc: 32'h400,
              taken: 1'b0, target: 32'h404}, 1, "hazb_release");

      // BEQ with both operands forwarded
      clear_inputs();
      rval_b = 32'h99; in_srca = 5'd1; in_srcb = 5'd2; in_usea = 1'b1; in_useb = 1'b1;
      set_ch(0, 1'b1, 1'b0, 5'd1, 32'h11);
      set_ch(1, 1'b1, 1'b0, 5'd2, 32'h11);
      in_brk = 3'd1; in_pc = 32'h100; in_imm = 32'h20;
      issue('{vala: 32'h11, valb: 32'h11, imm: 32'h20, dst: 5'd0, pc: 32'h100,
              taken: 1'b1, target: 32'h124}, 1, "beq_fwd");

      // Branch kinds from register-file operands
      for (int k = 0; k < NBR; k++) begin
         clear_inputs();
         in_srca = 5'd7; in_srcb = 5'd8; in_usea = 1'b1; in_useb = 1'b1;
         rval_a = BR_A[k]; rval_b = BR_B[k];
         in_brk = BR_K[k]; in_pc = BR_PC[k]; in_imm = BR_IMM[k]; in_dst = 5'(k);
         issue('{vala: BR_A[k], valb: BR_B[k], imm: BR_IMM[k], dst: 5'(k), pc: BR_PC[k],
                 taken: BR_TK[k], target: BR_TGT[k]}, 1, "branch");
      end
      clear_inputs();
      drain(20);

      // Backpressure: output holds, full stage blocks input, hazard still
      // counts while full, flush empties regardless of out_ready
      out_ready = 1'b0;
      rval_a = 32'hA1; rval_b = 32'hA1; in_brk = 3'd1;
      in_dst = 5'd31; in_pc = 32'h600; in_imm = 32'h40; in_valid = 1'b1;
      @(negedge clk);
      chk("hold_load_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      clear_inputs();
      in_pc = 32'h700; in_valid = 1'b1;
      @(negedge clk);
      chk("hold1_out_valid", 32'(out_valid), 32'd1);
      chk("hold1_out_pc",    out_pc,         32'h600);
      chk("hold1_out_vala",  out_vala,       32'hA1);
      chk("hold1_br_taken",  32'(br_taken),  32'd1);
      chk("hold1_in_ready",  32'(in_ready),  32'd0);
      @(posedge clk);
      #1;
      chk("hold_stall_none", 32'(stall_cnt), 32'd4);
      in_srca = 5'd3; in_usea = 1'b1;
      set_ch(0, 1'b1, 1'b1, 5'd3, 32'h0);
      @(negedge clk);
      chk("hold2_out_pc",    out_pc,         32'h600);
      chk("hold2_br_target", br_target,      32'h644);
      chk("hold2_out_dst",   32'(out_dst),   32'd31);
      chk("hold2_in_ready",  32'(in_ready),  32'd0);
      @(posedge clk);
      #1;
      chk("full_hazard_cnt", 32'(stall_cnt), 32'd5);
      flush = 1'b1;
      @(negedge clk);
      chk("flush_in_ready",  32'(in_ready),  32'd0);
      chk("flush_pre_valid", 32'(out_valid), 32'd1);
      @(posedge clk);
      #1;
      chk("flush_out_valid", 32'(out_valid), 32'd0);
      chk("flush_stall_cnt", 32'(stall_cnt), 32'd5);
      out_ready = 1'b1;

      // Flush blocks acceptance of an otherwise acceptable instruction
      clear_inputs();
      in_pc = 32'h800; in_valid = 1'b1; flush = 1'b1;
      @(negedge clk);
      chk("flush_block_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      chk("flush_block_valid", 32'(out_valid), 32'd0);

      // Sustained hazard saturates the counter
      clear_inputs();
      in_srca = 5'd9; in_usea = 1'b1; in_valid = 1'b1;
      set_ch(3, 1'b1, 1'b1, 5'd9, 32'h0);
      repeat (260) @(posedge clk);
      #1;
      chk("stall_sat", 32'(stall_cnt), SAT);
      @(posedge clk);
      #1;
      chk("stall_sat_hold", 32'(stall_cnt), SAT);

      // Asynchronous reset in the middle of a stall
      #1;
      resetn = 1'b0;
      #1;
      chk("arst_stall_cnt", 32'(stall_cnt), 32'd0);
      chk("arst_out_pc",    out_pc,         32'd0);
      chk("arst_out_vala",  out_vala,       32'd0);
      chk("arst_br_taken",  32'(br_taken),  32'd0);
      chk("arst_br_target", br_target,      32'd0);
      chk("arst_out_dst",   32'(out_dst),   32'd0);
      @(posedge clk);
      #1;
      clear_inputs();
      resetn = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", 32'(in_ready),  32'd1);
      chk("post_rst_valid", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      rval_a = 32'h3C; rval_b = 32'h4D; in_dst = 5'd1; in_pc = 32'h900; in_imm = 32'h8;
      issue('{vala: 32'h3C, valb: 32'h4D, imm: 32'h8, dst: 5'd1, pc: 32'h900,
              taken: 1'b0, target: 32'h90C}, 1, "post_rst");
      clear_inputs();
      drain(20);
      chk("post_rst_stall", 32'(stall_cnt), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/decode_fwd_stage.md
DECODE_FWD_STAGE -- requirements
Module: decode_fwd_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width.
REQ-002 SHALL have parameter REG_W, default 5, register-id width; id 0 is hardwired zero.
REQ-003 SHALL have parameter NUM_FWD, default 4, number of forwarding channels; index 0 is highest priority (youngest).
REQ-004 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-005 Ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  instruction accepted this cycle
- in_srca, in_srcb  in  REG_W  source register ids
- in_usea, in_useb  in  1  source is read
- in_dst  in  REG_W  destination id
- in_pc  in  DATA_W  instruction PC
- in_imm  in  DATA_W  immediate; pre-shifted branch offset for branches
- in_brk  in  3  branch kind: 0 none, 1 EQ, 2 NE, 3 LTZ, 4 GEZ, 5 LEZ, 6 GTZ
- rval_a, rval_b  in  DATA_W  register-file read data
- fwd_valid  in  NUM_FWD  channel carries a write
- fwd_pending  in  NUM_FWD  channel write data not yet available (load in flight)
- fwd_dst  in  NUM_FWD*REG_W  channel destination ids, packed
- fwd_data  in  NUM_FWD*DATA_W  channel data, packed
- flush  in  1  kill stage contents
- out_valid  out  1  output register holds an instruction
- out_ready  in  1  downstream accepts
- out_vala, out_valb  out  DATA_W  resolved operands
- out_imm  out  DATA_W  registered in_imm
- out_dst  out  REG_W  registered destination
- out_pc  out  DATA_W  registered PC
- br_taken  out  1  registered branch decision
- br_target  out  DATA_W  registered branch target
- stall_cnt  out  CNT_W  saturating hazard-stall count

Function
REQ-006 Operand resolution SHALL be combinational, per source: if the source is unused or its id is 0, use the register-file value; otherwise take the lowest-index channel i with fwd_valid[i] and fwd_dst[i]==src; if no channel matches, use the register-file value.
REQ-007 A hazard SHALL exist when a used, non-zero source's selected channel has fwd_pending set; lower-priority matches SHALL NOT override a pending higher-priority match.
REQ-008 in_ready SHALL equal !flush && !hazard && (!out_valid || out_ready).
REQ-009 On in_valid && in_ready, the output register SHALL load the resolved operands, imm, dst, pc and branch results, with out_valid=1 on the next cycle.
REQ-010 If out_valid && out_ready and no new instruction loads, out_valid SHALL go to 0; while !out_ready, all outputs SHALL hold.
REQ-011 br_target SHALL be in_pc+4+in_imm mod 2^DATA_W; br_taken SHALL use the resolved operands, signed compare against zero for kinds 3-6 and a compare against operand B for EQ/NE; kind 0 or 7 SHALL give br_taken=0.
REQ-012 flush SHALL clear out_valid on the next edge regardless of out_ready and SHALL block acceptance that cycle.
REQ-013 stall_cnt SHALL increment once per cycle with in_valid && hazard && !flush, saturating at 2^CNT_W-1.
REQ-014 Simultaneous hazard and full output: the hazard SHALL still count; in_ready=0.

Reset
REQ-015 On resetn low, asynchronously: out_valid=0, br_taken=0, stall_cnt=0, and all data outputs=0; reset deasserted mid-stall SHALL resume with a clean, empty stage.

Verification
REQ-016 rval_a=5, srca=3, channel 2 dst=3 data=9, channel 0 dst=3 data=7 -> out_vala=7 one cycle later.
REQ-017 srca=3 matches channel 0 with fwd_pending=1 for 3 cycles -> in_ready=0 for 3 cycles, stall_cnt=3, then accepted with the forwarded data.
REQ-018 srca=0, channel 0 dst=0 data=0xFFFF -> out_vala=rval_a.
REQ-019 BEQ, pc=0x100, imm=0x20, both operands forwarded =0x11 -> br_taken=1, br_target=0x124; BGTZ with a=0x80000000 -> br_taken=0.
REQ-020 out_valid=1, out_ready=0 for 2 cycles, then flush -> outputs hold 2 cycles, then out_valid=0; stall_cnt saturates at 0xFFFF under a sustained hazard.
